// File: rtl/lfsr_range_gen_if.sv
// Bus between the game FSM (master) and the LFSR range generator (slave).
// Carries the seed/request strobes in and the busy/valid/value results out.
// Build option: LFSR_RANGE_REJECT_EN adds the reject_cnt signal.
interface lfsr_range_gen_if #(
    parameter int WIDTH = 16,
    parameter int OUT_W = 12
);
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             req;
    logic             busy;
    logic             valid;
    logic [OUT_W-1:0] value;
    logic [WIDTH-1:0] lfsr_state;
`ifdef LFSR_RANGE_REJECT_EN
    logic [7:0]       reject_cnt;

    modport master (
        output seed_load, seed_in, req,
        input  busy, valid, value, lfsr_state, reject_cnt
    );

    modport slave (
        input  seed_load, seed_in, req,
        output busy, valid, value, lfsr_state, reject_cnt
    );
`else
    modport master (
        output seed_load, seed_in, req,
        input  busy, valid, value, lfsr_state
    );

    modport slave (
        input  seed_load, seed_in, req,
        output busy, valid, value, lfsr_state
    );
`endif
endinterface

// File: rtl/lfsr_range_gen.sv
// LFSR range generator: a free-running Fibonacci LFSR is snapshotted on
// request and reduced modulo (MAX_VAL-MIN_VAL+1) by a bit-serial restoring
// divider, then offset by MIN_VAL. No combinational modulo is used.
// Build option: LFSR_RANGE_REJECT_EN enables rejection sampling (snapshots
// at or above the largest multiple of the range are discarded and retaken
// on the next edge) and the saturating reject_cnt output.
module lfsr_range_gen #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] TAPS    = 16'hD008,
    parameter logic [WIDTH-1:0] SEED    = 16'hACE1,
    parameter int               OUT_W   = 12,
    parameter int               MIN_VAL = 500,
    parameter int               MAX_VAL = 3500
) (
    input  logic               clk,
    input  logic               reset,
    lfsr_range_gen_if.slave    bus
);

    // Number of distinct output values; one bit wider than the LFSR so a
    // full 2^WIDTH range still fits.
    localparam logic [WIDTH:0] RANGE = (WIDTH+1)'(MAX_VAL - MIN_VAL + 1);
    localparam int             CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef LFSR_RANGE_REJECT_EN
    // Largest multiple of RANGE not exceeding 2^WIDTH; snapshots at or above
    // it would bias the low residues, so they are discarded.
    localparam logic [WIDTH:0] POW2  = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] LIMIT = (POW2 / RANGE) * RANGE;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
`ifdef LFSR_RANGE_REJECT_EN
    localparam logic [1:0] S_REJ  = 2'd3;
`endif

    // Elaboration-time sanity checks on the parameter set.
    generate
        if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
            $error("lfsr_range_gen: WIDTH must be in 4..32");
        end
        if (SEED == '0) begin : g_bad_seed
            $error("lfsr_range_gen: SEED must be nonzero");
        end
        if (MAX_VAL < MIN_VAL) begin : g_bad_bounds
            $error("lfsr_range_gen: MAX_VAL must be >= MIN_VAL");
        end
        if (MAX_VAL >= (1 << OUT_W)) begin : g_bad_outw
            $error("lfsr_range_gen: MAX_VAL must fit in OUT_W bits");
        end
    endgenerate

    // One Fibonacci shift: feedback is the parity of the tapped bits.
    function automatic logic [WIDTH-1:0] lfsr_shift(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ^(v & TAPS)};
    endfunction

    // One restoring-division step: bring in the next dividend bit and
    // subtract the divisor when it fits. The remainder never exceeds the
    // dividend prefix, so it always fits back into WIDTH bits.
    function automatic logic [WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic             bit_in);
        logic [WIDTH:0] trial;
        logic [WIDTH:0] diff;
        trial = {rem, bit_in};
        diff  = trial - RANGE;
        return (trial >= RANGE) ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    endfunction

`ifdef LFSR_RANGE_REJECT_EN
    // Saturating 8-bit increment for the rejection counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
`endif

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_lfsr_nxt;
    logic [1:0]       r_state;
    logic             r_busy;
    logic             r_valid;
    logic [OUT_W-1:0] r_value;
    logic [WIDTH-1:0] r_snap;
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] w_result;
`ifdef LFSR_RANGE_REJECT_EN
    logic [7:0]       r_rej_cnt;
    logic             w_accept;
`endif

    // Next LFSR value: seed load wins, then the all-zero guard, then the shift.
    always_comb begin
        w_lfsr_nxt = lfsr_shift(r_lfsr);
        if (bus.seed_load) begin
            w_lfsr_nxt = (bus.seed_in == '0) ? SEED : bus.seed_in;
        end else if (r_lfsr == '0) begin
            w_lfsr_nxt = SEED;
        end
    end

    // Free-running LFSR register; advances every clock independent of the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    // Final remainder is below RANGE, so the offset result fits OUT_W bits.
    assign w_result = OUT_W'(r_rem) + OUT_W'(MIN_VAL);

`ifdef LFSR_RANGE_REJECT_EN
    assign w_accept = ({1'b0, r_lfsr} < LIMIT);
`endif

    // Request FSM: snapshot, WIDTH divider steps, then publish the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_value   <= OUT_W'(MIN_VAL);
            r_snap    <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
`ifdef LFSR_RANGE_REJECT_EN
            r_rej_cnt <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_busy <= 1'b1;
`ifdef LFSR_RANGE_REJECT_EN
                        if (w_accept) begin
                            r_rej_cnt <= '0;
                            r_snap    <= r_lfsr;
                            r_rem     <= '0;
                            r_cnt     <= CNT_W'(WIDTH - 1);
                            r_state   <= S_DIV;
                        end else begin
                            r_rej_cnt <= 8'd1;
                            r_state   <= S_REJ;
                        end
`else
                        r_snap  <= r_lfsr;
                        r_rem   <= '0;
                        r_cnt   <= CNT_W'(WIDTH - 1);
                        r_state <= S_DIV;
`endif
                    end
                end
`ifdef LFSR_RANGE_REJECT_EN
                S_REJ: begin
                    // Retake the snapshot each edge until it lands below LIMIT.
                    if (w_accept) begin
                        r_snap  <= r_lfsr;
                        r_rem   <= '0;
                        r_cnt   <= CNT_W'(WIDTH - 1);
                        r_state <= S_DIV;
                    end else begin
                        r_rej_cnt <= sat_inc8(r_rej_cnt);
                    end
                end
`endif
                S_DIV: begin
                    // Dividend bits are consumed MSB first.
                    r_rem <= div_step(r_rem, r_snap[r_cnt]);
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_value <= w_result;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.valid      = r_valid;
    assign bus.value      = r_value;
    assign bus.lfsr_state = r_lfsr;
`ifdef LFSR_RANGE_REJECT_EN
    assign bus.reject_cnt = r_rej_cnt;
`endif

endmodule
